// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared state encoding and width helper for the serial word path
package ser_pkg;

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_COLLECT = 1'b1;

  typedef enum logic {
    S_IDLE    = ST_IDLE,
    S_COLLECT = ST_COLLECT
  } ser_state_t;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/ser_word_slot.sv
// rtl/ser_word_slot.sv - single-entry output register with valid/ready and drop indication
module ser_word_slot #(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [w-1:0] load_word,
  input  logic         word_rdy,
  output logic [w-1:0] word_out,
  output logic         word_vld,
  output logic         drop
);

  // A word leaving this cycle frees the slot for a same-cycle load.
  logic slot_free;
  assign slot_free = !word_vld || word_rdy;
  assign drop      = load && !slot_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_out <= '0;
      word_vld <= 1'b0;
    end else if (load && slot_free) begin
      word_out <= load_word;
      word_vld <= 1'b1;
    end else if (word_vld && word_rdy) begin
      word_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/ser_word_collector.sv
// rtl/ser_word_collector.sv - reassembles LSB-first serial bits into w-bit words
module ser_word_collector
  import ser_pkg::*;
#(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_vld,
  input  logic         bit_in,
  input  logic         flush,
  input  logic         word_rdy,
  input  logic         clr_err,
  output logic [w-1:0] word_out,
  output logic         word_vld,
  output logic         busy,
  output logic         ovf
);

  localparam int CW = cnt_width(w);
  localparam logic [CW-1:0] CNT_LAST = CW'(w - 1);

  ser_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [w-1:0]  acc_q, acc_d;
  logic [w-1:0]  shifted;
  logic          load;
  logic          drop;

  // The LSB only ever falls off the end of the shift, so it is never read.
  logic unused_acc_lsb;
  assign unused_acc_lsb = acc_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    load    = 1'b0;
    shifted = {bit_in, acc_q[w-1:1]};
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (bit_vld) begin
      acc_d = shifted;
      if (state_q == S_COLLECT && cnt_q == CNT_LAST) begin
        load    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = S_COLLECT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      if (drop)
        ovf <= 1'b1;
      else if (clr_err)
        ovf <= 1'b0;
    end
  end

  assign busy = (state_q == S_COLLECT);

  ser_word_slot #(.w(w)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_word (shifted),
    .word_rdy  (word_rdy),
    .word_out  (word_out),
    .word_vld  (word_vld),
    .drop      (drop)
  );

endmodule

// File: tb/tb_ser_word_collector.sv
// tb/tb_ser_word_collector.sv - self-checking bench for ser_word_collector
module tb_ser_word_collector;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, bit_vld, bit_in, flush, word_rdy, clr_err;
  logic [W-1:0] word_out;
  logic         word_vld, busy, ovf;

  always #5 clk = ~clk;

  ser_word_collector #(.w(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bit_vld  (bit_vld),
    .bit_in   (bit_in),
    .flush    (flush),
    .word_rdy (word_rdy),
    .clr_err  (clr_err),
    .word_out (word_out),
    .word_vld (word_vld),
    .busy     (busy),
    .ovf      (ovf)
  );

  int           vec_cnt = 0;
  int           err_cnt = 0;
  logic [W-1:0] sb[$];

  typedef struct {
    logic [W-1:0] data;
    int           maxgap;
    logic [W-1:0] exp_word;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Runs just before each edge: a word offered with ready high is consumed at that edge.
  task automatic monitor();
    if (rst) begin
      sb.delete();
    end else if (word_vld === 1'b1 && word_rdy) begin
      if (sb.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL sb_unexpected: got word %0h, required none", word_out);
      end else begin
        check("sb_word", 32'(word_out), 32'(sb.pop_front()));
      end
    end
  endtask

  task automatic tick();
    monitor();
    @(posedge clk);
    #1;
  endtask

  function automatic int gap_of(input int maxgap);
    return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 1));
  endfunction

  task automatic send_bit(input logic b, input int gap);
    bit_vld = 1'b0;
    bit_in  = 1'bx;
    repeat (gap) tick();
    bit_vld = 1'b1;
    bit_in  = b;
    tick();
    bit_vld = 1'b0;
    bit_in  = 1'bx;
  endtask

  task automatic send_bits(input logic [W-1:0] data, input int n, input int maxgap);
    for (int i = 0; i < n; i++)
      send_bit(data[i], gap_of(maxgap));
  endtask

  task automatic send_word(input logic [W-1:0] data, input int maxgap, input bit accept);
    send_bits(data, W - 1, maxgap);
    if (accept)
      sb.push_back(data);
    send_bit(data[W-1], gap_of(maxgap));
  endtask

  initial begin
    tbl[0] = '{data: 8'hAA, maxgap: 0, exp_word: 8'hAA};
    tbl[1] = '{data: 8'hF0, maxgap: 3, exp_word: 8'hF0};
    tbl[2] = '{data: 8'h00, maxgap: 1, exp_word: 8'h00};
    tbl[3] = '{data: 8'hFF, maxgap: 0, exp_word: 8'hFF};
    tbl[4] = '{data: 8'h5A, maxgap: 2, exp_word: 8'h5A};
    tbl[5] = '{data: 8'h81, maxgap: 3, exp_word: 8'h81};

    rst = 1'b1; bit_vld = 1'b0; bit_in = 1'b0; flush = 1'b0; word_rdy = 1'b1; clr_err = 1'b0;
    repeat (2) tick();
    check("rst_vld",  32'(word_vld), 32'h0);
    check("rst_word", 32'(word_out), 32'h0);
    check("rst_busy", 32'(busy),     32'h0);
    check("rst_ovf",  32'(ovf),      32'h0);
    rst = 1'b0;
    tick();

    // Streaming words with ready held high, with and without bit gaps.
    for (int v = 0; v < 6; v++) begin
      send_bits(tbl[v].data, W - 1, tbl[v].maxgap);
      check("busy_mid",  32'(busy),     32'h1);
      check("vld_early", 32'(word_vld), 32'h0);
      sb.push_back(tbl[v].exp_word);
      send_bit(tbl[v].data[W-1], gap_of(tbl[v].maxgap));
      check("tbl_vld",  32'(word_vld), 32'h1);
      check("tbl_word", 32'(word_out), 32'(tbl[v].exp_word));
      check("tbl_busy", 32'(busy),     32'h0);
      check("tbl_ovf",  32'(ovf),      32'h0);
    end
    tick();
    check("drain_vld", 32'(word_vld), 32'h0);

    // Overflow: slot held, second word dropped, drop beats clr_err.
    word_rdy = 1'b0;
    send_word(8'hAA, 0, 1'b1);
    send_word(8'h0F, 0, 1'b0);
    check("ovf_hold_word", 32'(word_out), 32'hAA);
    check("ovf_set",       32'(ovf),      32'h1);
    send_bits(8'h12, W - 1, 0);
    clr_err = 1'b1;
    send_bit(1'b0, 0);
    clr_err = 1'b0;
    check("ovf_set_wins", 32'(ovf), 32'h1);
    word_rdy = 1'b1;
    tick();
    check("ovf_drain_vld", 32'(word_vld), 32'h0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("ovf_clr", 32'(ovf), 32'h0);

    // Back-to-back: ready in the completion cycle of the next word.
    word_rdy = 1'b0;
    send_word(8'h11, 0, 1'b1);
    send_bits(8'h22, W - 1, 0);
    word_rdy = 1'b1;
    sb.push_back(8'h22);
    send_bit(1'b0, 0);
    check("b2b_vld",  32'(word_vld), 32'h1);
    check("b2b_word", 32'(word_out), 32'h22);
    check("b2b_ovf",  32'(ovf),      32'h0);
    tick();

    // Flush mid-word with a bit offered; pending output is untouched.
    word_rdy = 1'b0;
    send_word(8'h55, 0, 1'b1);
    send_bits(8'hFF, 5, 0);
    flush = 1'b1; bit_vld = 1'b1; bit_in = 1'b1;
    tick();
    flush = 1'b0; bit_vld = 1'b0;
    check("flush_busy", 32'(busy),     32'h0);
    check("flush_vld",  32'(word_vld), 32'h1);
    check("flush_word", 32'(word_out), 32'h55);
    word_rdy = 1'b1;
    tick();
    send_word(8'h3C, 1, 1'b1);
    check("flush_new_word", 32'(word_out), 32'h3C);

    // Flush on the completing bit: no word, no overflow.
    send_bits(8'hC3, W - 1, 0);
    flush = 1'b1; bit_vld = 1'b1; bit_in = 1'b1;
    tick();
    flush = 1'b0; bit_vld = 1'b0;
    check("flush_cmp_vld",  32'(word_vld), 32'h0);
    check("flush_cmp_busy", 32'(busy),     32'h0);
    check("flush_cmp_ovf",  32'(ovf),      32'h0);
    send_word(8'hE7, 0, 1'b1);
    check("flush_cmp_next", 32'(word_out), 32'hE7);
    tick();

    // Reset mid-word with a pending word and ovf set.
    word_rdy = 1'b0;
    send_word(8'h77, 0, 1'b1);
    send_word(8'h99, 0, 1'b0);
    check("pre_rst_ovf", 32'(ovf), 32'h1);
    send_bits(8'hFF, 4, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_vld",  32'(word_vld), 32'h0);
    check("mid_rst_word", 32'(word_out), 32'h0);
    check("mid_rst_busy", 32'(busy),     32'h0);
    check("mid_rst_ovf",  32'(ovf),      32'h0);
    send_word(8'h81, 0, 1'b1);
    check("post_rst_word", 32'(word_out), 32'h81);

    // A reset pulse between edges must not be seen.
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    check("glitch_vld",  32'(word_vld), 32'h1);
    check("glitch_word", 32'(word_out), 32'h81);
    word_rdy = 1'b1;
    tick();
    check("final_vld", 32'(word_vld), 32'h0);
    check("sb_empty",  32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
